// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline stage registers and the hazard logic.
package pipe_skid_stage_pkg;

    localparam int BIN_DIG = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } pipe_occ_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
import pipe_skid_stage_pkg::*;

interface pipe_skid_stage_if #(
    parameter int WIDTH = BIN_DIG
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter shared by the performance-debug counters.
import pipe_skid_stage_pkg::*;

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with a 2-entry skid buffer, synchronous flush and stall counter.
//
//   state     | meaning
//   OCC_EMPTY | nothing held, out_valid low
//   OCC_ONE   | main entry valid, skid empty
//   OCC_FULL  | main and skid valid, in_ready low
import pipe_skid_stage_pkg::*;

module pipe_skid_stage #(
    parameter int WIDTH = BIN_DIG,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    pipe_skid_stage_if.slave  up,
    pipe_skid_stage_if.master dn,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    pipe_occ_e        occ_q, occ_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             main_v, skid_v;
    logic             in_fire, out_fire;
    logic             load_main_in, load_main_skid, load_skid;
    logic             stall_inc;

    assign main_v = (occ_q != OCC_EMPTY);
    assign skid_v = (occ_q == OCC_FULL);

    // in_ready depends only on state, so out_ready never reaches it combinationally
    assign up.ready  = !skid_v;
    assign dn.valid  = main_v;
    assign dn.data   = main_q;
    assign occupancy = occ_q;

    assign in_fire  = up.valid && !skid_v;
    assign out_fire = main_v && dn.ready;

    always_comb begin
        occ_d          = occ_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    occ_d        = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    occ_d = OCC_EMPTY;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    occ_d     = OCC_FULL;
                end
            end
            OCC_FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    occ_d          = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // flush only drops the valid state; payload flops keep their contents
        if (flush) begin
            occ_d          = OCC_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            occ_q  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (load_main_in) begin
                main_q <= up.data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= up.data;
            end
        end
    end

    assign stall_inc = main_v && !dn.ready && !flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed, table-driven bench for pipe_skid_stage plus a 4-bit stall counter instance.
import pipe_skid_stage_pkg::*;

module tb_pipe_skid_stage;

    localparam int W = BIN_DIG;

    logic         CLK;
    logic         RST;
    logic         flush;
    logic         flush4;
    logic [1:0]   occupancy, occupancy4;
    logic [15:0]  stall_cycles;
    logic [3:0]   stall_cycles4;

    int tests = 0;
    int fails = 0;

    pipe_skid_stage_if #(.WIDTH(W)) up_if ();
    pipe_skid_stage_if #(.WIDTH(W)) dn_if ();
    pipe_skid_stage_if #(.WIDTH(W)) up4_if ();
    pipe_skid_stage_if #(.WIDTH(W)) dn4_if ();

    pipe_skid_stage #(.WIDTH(W), .CNT_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .flush        (flush),
        .up           (up_if),
        .dn           (dn_if),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    pipe_skid_stage #(.WIDTH(W), .CNT_W(4)) dut4 (
        .CLK          (CLK),
        .RST          (RST),
        .flush        (flush4),
        .up           (up4_if),
        .dn           (dn4_if),
        .occupancy    (occupancy4),
        .stall_cycles (stall_cycles4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [W-1:0]  e_od;
        logic          e_ir;
        logic [1:0]    e_occ;
        logic [15:0]   e_stall;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] delivered[$];
    logic [W-1:0] exp_deliv[$];

    always @(posedge CLK) begin
        if (RST && dn_if.valid && dn_if.ready) delivered.push_back(dn_if.data);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input logic [W-1:0] d, input logic ordy,
                                input logic fl, input logic e_ov, input logic [W-1:0] e_od,
                                input logic e_ir, input logic [1:0] e_occ, input logic [15:0] e_stall);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ; v.e_stall = e_stall;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        up_if.valid = iv;
        up_if.data  = d;
        dn_if.ready = ordy;
        flush       = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic e_ov, input logic [W-1:0] e_od,
                                 input logic e_ir, input logic [1:0] e_occ, input logic [15:0] e_stall);
        check({tag, " out_valid"}, 64'(dn_if.valid), 64'(e_ov));
        if (e_ov) check({tag, " out_data"}, 64'(dn_if.data), 64'(e_od));
        check({tag, " in_ready"}, 64'(up_if.ready), 64'(e_ir));
        check({tag, " occupancy"}, 64'(occupancy), 64'(e_occ));
        check({tag, " stall"}, 64'(stall_cycles), 64'(e_stall));
    endtask

    initial begin
        // stream 1..8 with out_ready high, then drain
        for (int i = 1; i <= 8; i++) add(1, W'(i), 1, 0, 1, W'(i), 1, 2'd1, 16'd0);
        add(0, '0, 1, 0, 0, '0, 1, 2'd0, 16'd0);
        // back-pressure: A, B accepted, C held upstream
        add(1, 32'hA, 0, 0, 1, 32'hA, 1, 2'd1, 16'd0);
        add(1, 32'hB, 0, 0, 1, 32'hA, 0, 2'd2, 16'd1);
        add(1, 32'hC, 0, 0, 1, 32'hA, 0, 2'd2, 16'd2);
        add(1, 32'hC, 0, 0, 1, 32'hA, 0, 2'd2, 16'd3);
        add(1, 32'hC, 1, 0, 1, 32'hB, 1, 2'd1, 16'd3);
        add(1, 32'hC, 1, 0, 1, 32'hC, 1, 2'd1, 16'd3);
        add(0, '0, 1, 0, 0, '0, 1, 2'd0, 16'd3);
        // flush in FULL with in_valid high
        add(1, 32'h11, 0, 0, 1, 32'h11, 1, 2'd1, 16'd3);
        add(1, 32'h22, 0, 0, 1, 32'h11, 0, 2'd2, 16'd4);
        add(1, 32'h33, 0, 1, 0, '0, 1, 2'd0, 16'd4);
        add(0, '0, 1, 0, 0, '0, 1, 2'd0, 16'd4);
        // flush in ONE discards the beat accepted that cycle
        add(1, 32'h44, 0, 0, 1, 32'h44, 1, 2'd1, 16'd4);
        add(1, 32'h55, 0, 1, 0, '0, 1, 2'd0, 16'd4);
        add(0, '0, 1, 0, 0, '0, 1, 2'd0, 16'd4);
        // flush together with out_fire: 0x66 delivered exactly once
        add(1, 32'h66, 1, 0, 1, 32'h66, 1, 2'd1, 16'd4);
        add(0, '0, 1, 1, 0, '0, 1, 2'd0, 16'd4);
        add(0, '0, 1, 0, 0, '0, 1, 2'd0, 16'd4);

        for (int i = 1; i <= 8; i++) exp_deliv.push_back(W'(i));
        exp_deliv.push_back(32'hA);
        exp_deliv.push_back(32'hB);
        exp_deliv.push_back(32'hC);
        exp_deliv.push_back(32'h66);
        exp_deliv.push_back(32'h77);

        up_if.valid = 0; up_if.data = '0; dn_if.ready = 0; flush = 0;
        up4_if.valid = 0; up4_if.data = '0; dn4_if.ready = 0; flush4 = 0;
        RST = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs("reset", 0, '0, 1, 2'd0, 16'd0);
        check("reset out_data", 64'(dn_if.data), 64'd0);
        RST = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od,
                          vecs[i].e_ir, vecs[i].e_occ, vecs[i].e_stall);
        end

        // async reset while FULL, asserted between edges
        step(1, 32'hE1, 0, 0);
        step(1, 32'hE2, 0, 0);
        check("pre-areset occupancy", 64'(occupancy), 64'd2);
        #2;
        RST = 0;
        #1;
        check_outputs("areset", 0, '0, 1, 2'd0, 16'd0);
        check("areset out_data", 64'(dn_if.data), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1;
        step(1, 32'h77, 1, 0);
        check_outputs("post-reset accept", 1, 32'h77, 1, 2'd1, 16'd0);
        step(0, '0, 1, 0);
        check_outputs("post-reset drain", 0, '0, 1, 2'd0, 16'd0);

        check("delivered count", 64'(delivered.size()), 64'(exp_deliv.size()));
        for (int i = 0; i < exp_deliv.size() && i < delivered.size(); i++)
            check($sformatf("delivered[%0d]", i), 64'(delivered[i]), 64'(exp_deliv[i]));

        // 4-bit stall counter saturation
        up4_if.valid = 1; up4_if.data = 32'h5;
        @(posedge CLK); #1;
        up4_if.valid = 0;
        check("sat accept", 64'(dn4_if.valid), 64'd1);
        repeat (14) @(posedge CLK);
        #1;
        check("sat 14", 64'(stall_cycles4), 64'd14);
        repeat (6) @(posedge CLK);
        #1;
        check("sat 20", 64'(stall_cycles4), 64'hF);
        repeat (3) @(posedge CLK);
        #1;
        check("sat hold", 64'(stall_cycles4), 64'hF);
        check("sat data held", 64'(dn4_if.data), 64'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline-stage register that replaces the free-running stage-to-stage registers between fetch, decode, execute/dmem and writeback. It carries an opaque WIDTH-bit payload with a valid/ready handshake. A 2-entry skid buffer gives full throughput with no combinational path from out_ready to in_ready. The block adds a synchronous flush for branch redirects and a saturating stall counter for performance debug.

## Interface
- WIDTH, default BIN_DIG (32): payload width in bits (PC, instruction, decoded fields packed by the instantiating stage).
- CNT_W, default 16: stall counter width.

- CLK  input  1  clock; all state changes on posedge.
- RST  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; driven only by state flops.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload (main entry).
- occupancy  output  2  held entries: 0, 1 or 2.
- stall_cycles  output  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage:
  - main entry (main_q, main_v) drives out_data and out_valid.
  - skid entry (skid_q, skid_v) absorbs one beat while the output is blocked.
- Handshake events:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
  - Once out_valid is high, the payload stays stable until out_fire or flush.
- in_ready = !skid_v.
- States (occupancy encoding):
  - EMPTY (0): in_fire -> main <= in_data, go to ONE.
  - ONE (1):
    - in_fire && out_fire -> main <= in_data, stay ONE.
    - out_fire only -> EMPTY.
    - in_fire only -> skid <= in_data, go to FULL.
    - neither -> hold.
  - FULL (2): in_ready = 0.
    - out_fire -> main <= skid, go to ONE.
    - otherwise hold.
- Flush has priority over every transition:
  - Next state is EMPTY.
  - A beat accepted by in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered; the consumer owns it.
  - Data flops are not cleared; only the valid bits are cleared.
- Stall counter:
  - Increments when out_valid && !out_ready && !flush.
  - Saturates at all-ones and never wraps.
  - Cleared only by RST.
- Reset (RST low, asynchronous):
  - main_v = skid_v = 0; main_q = skid_q = 0.
  - out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0, stall_cycles = 0.
- Reset asserted mid-transfer drops all held beats; the first legal acceptance is at the first posedge after RST deasserts.

## Timing
- Latency from in_fire to out_valid: 1 cycle when EMPTY, or ONE with out_fire in the same cycle.
- Throughput: 1 beat/cycle sustained while out_ready stays high.
- When out_ready drops, one extra beat is absorbed, then in_ready falls on the next edge.
- in_ready, out_valid, out_data and occupancy are pure flop outputs (no combinational input-to-output path).
- flush takes effect at the same edge; out_valid is 0 in the following cycle.

## Structure
- Package defs:
  - BIN_DIG (existing).
  - New typedef enum logic [1:0] pipe_occ_e {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_FULL = 2'd2}, shared by the stage and hazard logic.
- One sub-module: sat_counter (parameter CNT_W, inputs inc/RST/CLK, output count), which is reused by other perf counters.
- Stage wrappers instantiate pipe_skid_stage with WIDTH = $bits of their packed payload struct.

## Test plan
- Reset then stream: RST low for 3 cycles, then in_data 0x00000001..0x00000008 with out_ready = 1 -> outputs appear in order 1 cycle later, in_ready stays 1, stall_cycles = 0.
- Back-pressure: send 0xA, 0xB, 0xC while out_ready = 0 -> 0xA and 0xB are accepted, in_ready = 0 with occupancy = 2, and 0xC is held upstream. Raise out_ready -> 0xA, 0xB, 0xC are delivered in order, and stall_cycles equals the number of cycles out_ready was low with out_valid high.
- Flush in FULL with in_valid = 1 -> the next cycle shows out_valid = 0, occupancy = 0, in_ready = 1, and the flush-cycle beat never appears.
- Simultaneous flush and out_fire: out_ready = 1 with flush = 1 in the same cycle -> the held beat counts as delivered once, and nothing follows it.
- Stall saturation: CNT_W = 4, out_ready = 0 for 20 cycles -> stall_cycles = 0xF and holds.
- Async reset mid-FULL: RST pulsed low between edges -> outputs reach their reset values immediately, without waiting for an edge.
